// File: rtl/prog_mem_sync.sv
// Program memory with a CPU read/write port and a streaming full-image loader.
//
// The CPU sees a window of DEPTH words starting at address BASE. Reads are
// registered: the word for the address presented at an edge appears on
// data_out after that edge, and hit tells whether that address was inside
// the window. While an image load is in progress (busy=1) the CPU port is
// frozen: writes are dropped and data_out/hit hold their last values.
//
// Load handshake: a word transfers on an edge where load_ready=1 and
// load_valid=1. load_ready is high only in LOAD. A low load_valid stalls the
// load indefinitely without changing anything. After the word for the last
// index is accepted the block spends exactly one cycle in DONE with
// load_done=1, then returns to IDLE.
//
// Storage is deliberately not reset, so a reset in the middle of a load
// keeps every word written so far and leaves the remaining words untouched.
// fsm_state exposes the controller state (0=IDLE, 1=LOAD, 2=DONE).

module prog_mem_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              hit,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              load_done,
  output logic [1:0]        fsm_state
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so that address - BASE can signal "below the window".
  localparam int AXW = ADDR_W + 1;
  localparam logic [AXW-1:0]   BASE_X   = AXW'(BASE);
  localparam logic [AXW-1:0]   DEPTH_X  = AXW'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Reject window geometries that do not fit the address space.
  if ((BASE < 0) || (BASE + DEPTH > (1 << ADDR_W)) || (DEPTH < 2)) begin : g_param_err
    $error("prog_mem_sync: BASE+DEPTH must fit in 2**ADDR_W and DEPTH must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AXW-1:0]    offset;
  logic              in_win;
  logic [IDX_W-1:0]  cpu_idx;
  logic              idle;
  logic              cpu_we;
  logic              load_we;

  // Address decode: a negative offset sets the top bit, so one subtract
  // covers both window bounds.
  assign offset  = {1'b0, address} - BASE_X;
  assign in_win  = ~offset[ADDR_W] && (offset < DEPTH_X);
  assign cpu_idx = offset[IDX_W-1:0];

  assign idle    = (state_q == S_IDLE);
  assign cpu_we  = idle && write && in_win;
  assign load_we = (state_q == S_LOAD) && load_valid;

  assign busy       = !idle;
  assign load_ready = (state_q == S_LOAD);
  assign load_done  = (state_q == S_DONE);
  assign fsm_state  = state_q;

  // Next-state and load counter: counter cleared on entry to LOAD, advanced
  // per accepted word, and never stepped past the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage write port; CPU and loader writes are exclusive by state.
  always_ff @(posedge clk) begin
    if (cpu_we) begin
      mem[cpu_idx] <= data_in;
    end else if (load_we) begin
      mem[cnt_q] <= load_data;
    end
  end

  // Registered CPU read; samples the pre-edge word (read-before-write) and
  // holds everything while a load owns the memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      hit      <= 1'b0;
    end else if (idle) begin
      hit <= in_win;
      if (in_win) begin
        data_out <= mem[cpu_idx];
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_sync.sv
// Self-checking bench for prog_mem_sync: a BASE=0 instance driven by the CPU
// and loader, plus a BASE=0x40 instance sharing the load stream for window
// boundary checks. Expected values come from a word-array reference model.

module tb_prog_mem_sync;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int DEPTH  = 128;
  localparam int BASE_B = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] address = '1;
  logic [DW-1:0] data_in = '0;
  logic          write = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [DW-1:0] data_out;
  logic          hit, load_ready, busy, load_done;
  logic [1:0]    fsm_state;

  logic [AW-1:0] b_address = '1;
  logic          b_write = 1'b0;
  logic [DW-1:0] b_data_out;
  logic          b_hit, b_load_ready, b_busy, b_load_done;
  logic [1:0]    b_fsm_state;

  prog_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .data_in(data_in),
    .write(write), .data_out(data_out), .hit(hit), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .busy(busy), .load_done(load_done), .fsm_state(fsm_state)
  );

  prog_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE(BASE_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_address), .data_in(data_in),
    .write(b_write), .data_out(b_data_out), .hit(b_hit), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(b_load_ready),
    .busy(b_busy), .load_done(b_load_done), .fsm_state(b_fsm_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];
  bit            m_loading = 1'b0;
  bit            m_done = 1'b0;
  int            m_next = 0;
  logic [DW-1:0] exp_dout = '0;
  bit            exp_hit = 1'b0;
  logic [DW-1:0] b_exp_dout = '0;
  bit            b_exp_hit = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            done_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the block's rules to the inputs sampled at this edge.
  task automatic model_edge();
    int ai;
    int bi;
    ai = int'(address);
    bi = int'(b_address);
    if (!(m_loading || m_done)) begin
      if (ai < DEPTH) begin
        exp_q.push_back(m_mem[ai]);
        exp_hit = 1'b1;
        if (write) m_mem[ai] = data_in;
      end else begin
        exp_hit = 1'b0;
      end
      if (bi >= BASE_B && bi < BASE_B + DEPTH) begin
        b_exp_dout = b_mem[bi - BASE_B];
        b_exp_hit  = 1'b1;
      end else begin
        b_exp_hit = 1'b0;
      end
      if (load_start) begin
        m_loading = 1'b1;
        m_next    = 0;
      end
    end else if (m_loading) begin
      if (load_valid) begin
        m_mem[m_next] = load_data;
        b_mem[m_next] = load_data;
        if (m_next == DEPTH - 1) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end else begin
          m_next++;
        end
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check_outputs();
    if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
    check("busy", busy, m_loading || m_done);
    check("load_ready", load_ready, m_loading);
    check("load_done", load_done, m_done);
    check("hit", hit, exp_hit);
    check("data_out", data_out, exp_dout);
    check("b_busy", b_busy, m_loading || m_done);
    check("b_hit", b_hit, b_exp_hit);
    check("b_data_out", b_data_out, b_exp_dout);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives inputs for one rising edge and checks.
  task automatic cyc(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit wr,
                     input bit ls, input bit lv, input logic [DW-1:0] ld,
                     input logic [AW-1:0] ba);
    address = a; data_in = d; write = wr;
    load_start = ls; load_valid = lv; load_data = ld; b_address = ba;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (load_done) done_count++;
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic [AW-1:0] a);
    cyc(a, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
  endtask

  // Asserts reset between edges so the async response is observable.
  task automatic apply_reset();
    address = '1; b_address = '1; write = 1'b0;
    load_start = 1'b0; load_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    m_loading = 1'b0; m_done = 1'b0;
    exp_dout = '0; exp_hit = 1'b0; b_exp_dout = '0; b_exp_hit = 1'b0;
    exp_q.delete();
    check("rst_busy", busy, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_hit", hit, 1'b0);
    check("rst_fsm_state", fsm_state, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Full load; valid drops every third cycle, CPU noise runs alongside.
  task automatic run_load(input int pattern, input bit noisy);
    int i;
    int k;
    logic [DW-1:0] w;
    bit lv;
    i = 0;
    k = 0;
    while (i < DEPTH && k < 1000) begin
      lv = (k % 3) != 2;
      w = (pattern == 0) ? (8'(i) ^ 8'h3C) : 8'($urandom);
      if (noisy)
        cyc(8'($urandom_range(0, 255)), 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0, lv, w, 8'hFF);
      else
        cyc(8'hFF, 8'h00, 1'b0, 1'b0, lv, w, 8'hFF);
      if (lv) i++;
      k++;
    end
    check("load_words_accepted", i, DEPTH);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset state at time zero (reset already low).
    #1;
    check("init_busy", busy, 1'b0);
    check("init_data_out", data_out, 8'h00);
    check("init_hit", hit, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Give storage defined contents.
    cyc(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    run_load(1, 1'b0);
    idle_cyc(8'hFF);

    // Reset again, then a plain read of 0x05.
    apply_reset();
    idle_cyc(8'h05);
    check("read_05_hit", hit, 1'b1);

    // Write then read back; out-of-window read holds data.
    cyc(8'h10, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    idle_cyc(8'h10);
    check("read_10", data_out, 8'hA5);
    idle_cyc(8'h80);
    check("read_80_hold", data_out, 8'hA5);
    check("read_80_hit", hit, 1'b0);

    // Read-before-write on the same index.
    cyc(8'h20, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    cyc(8'h20, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    check("rbw_old", data_out, 8'h11);
    idle_cyc(8'h20);
    check("rbw_new", data_out, 8'h22);

    // Random CPU traffic, stray load_valid while idle.
    for (int n = 0; n < 200; n++)
      cyc(8'($urandom_range(0, 255)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0,
          1'($urandom_range(0, 1)), 8'($urandom), 8'hFF);

    // Image load i^0x3C with a CPU write on the start cycle.
    done_count = 0;
    cyc(8'h30, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
    run_load(0, 1'b1);
    idle_cyc(8'hFF);
    check("load_done_pulses", done_count, 1);
    for (int j = 0; j < DEPTH; j++) begin
      idle_cyc(8'(j));
      check("img_readback", data_out, 8'(j) ^ 8'h3C);
    end

    // Window edges on the BASE=0x40 instance.
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3F);
    check("b_3f_miss", b_hit, 1'b0);
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40);
    check("b_40_word0", b_data_out, 8'h3C);
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hBF);
    check("b_bf_word127", b_data_out, 8'h43);
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC0);
    check("b_c0_miss", b_hit, 1'b0);
    check("b_c0_hold", b_data_out, 8'h43);

    // Reset after ten load words.
    idle_cyc(8'hFF);
    cyc(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    for (int j = 0; j < 10; j++)
      cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'(j) + 8'h80, 8'hFF);
    apply_reset();
    for (int j = 0; j < DEPTH; j++) begin
      idle_cyc(8'(j));
      check("partial_readback", data_out, (j < 10) ? (8'(j) + 8'h80) : (8'(j) ^ 8'h3C));
    end

    // Fresh load restarts at word 0.
    cyc(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 8'hFF);
    for (int j = 1; j < DEPTH; j++)
      cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'($urandom), 8'hFF);
    idle_cyc(8'hFF);
    idle_cyc(8'h00);
    check("restart_word0", data_out, 8'h77);
    for (int n = 0; n < 40; n++)
      idle_cyc(8'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_mem_sync.md
PROG_MEM_SYNC -- requirements
Module: prog_mem_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, CPU address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 128, number of storage words.
REQ-004 The block SHALL have parameter BASE, default 0, first CPU address mapped to word 0.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 address  input  ADDR_W  CPU read/write address.
REQ-009 data_in  input  DATA_W  CPU write data.
REQ-010 write  input  1  CPU write strobe.
REQ-011 data_out  output  DATA_W  registered read data.
REQ-012 hit  output  1  registered flag: the previous cycle's address was inside the window.
REQ-013 load_start  input  1  single-cycle request to begin a full-image load.
REQ-014 load_valid  input  1  load_data is valid this cycle.
REQ-015 load_data  input  DATA_W  image word.
REQ-016 load_ready  output  1  block accepts a load word this cycle.
REQ-017 busy  output  1  load in progress; CPU port blocked.
REQ-018 load_done  output  1  one-cycle pulse after the final image word is written.

Function
REQ-019 Window: address is in window iff BASE <= address < BASE+DEPTH; word index = address - BASE, width clog2(DEPTH).
REQ-020 BASE+DEPTH > 2**ADDR_W or DEPTH < 2 SHALL be a parameter error (elaboration-time check).
REQ-021 Read latency SHALL be exactly 1 cycle: in-window address at edge N -> data_out = mem[index] after edge N.
REQ-022 Out-of-window address SHALL leave data_out unchanged; hit SHALL register 0.
REQ-023 CPU write (write=1, in window, state IDLE) SHALL store data_in at mem[index] on the edge.
REQ-024 Read and write to the same index in the same cycle SHALL return the old word on data_out (read-before-write).
REQ-025 Out-of-window writes SHALL be ignored with no side effect.
REQ-026 FSM states: IDLE, LOAD, DONE.
REQ-027 IDLE: load_ready=0, busy=0; load_start=1 -> LOAD with load counter cleared to 0.
REQ-028 LOAD: busy=1, load_ready=1; on load_valid=1, write load_data to mem[counter] and increment counter.
REQ-029 LOAD: the accepted word at counter=DEPTH-1 SHALL move the FSM to DONE; load_valid=0 stalls indefinitely with no change.
REQ-030 DONE: lasts one cycle with load_done=1, busy=1, load_ready=0, then returns to IDLE.
REQ-031 While busy=1, CPU writes SHALL be ignored and data_out/hit SHALL hold their values.
REQ-032 load_start in LOAD or DONE SHALL be ignored; load_valid outside LOAD SHALL be ignored.
REQ-033 load_start and write in the same IDLE cycle: the CPU write SHALL complete, and the FSM SHALL enter LOAD.
REQ-034 The counter SHALL never exceed DEPTH-1; no wrap to word 0 within one load.

Reset
REQ-035 reset_n=0 SHALL asynchronously force IDLE, counter=0, data_out=0, hit=0, load_ready=0, busy=0, load_done=0.
REQ-036 Storage contents SHALL NOT be cleared by reset; words written before a mid-load reset remain, later words remain old.
REQ-037 After reset release, the first operation SHALL occur on the first rising edge with reset_n=1.

Verification
REQ-038 Reset with DATA_W=8, DEPTH=128, BASE=0 -> all outputs 0; address=0x05 after release -> data_out=mem[5] one cycle later, hit=1.
REQ-039 write 0xA5 to 0x10, then read 0x10 -> data_out=0xA5; read 0x80 -> data_out holds 0xA5, hit=0.
REQ-040 Same-cycle read/write to 0x20 holding 0x11 with data_in=0x22 -> data_out=0x11; next read -> 0x22.
REQ-041 load_start, then 128 words i^0x3C with load_valid low every 3rd cycle -> load_done pulses once, one cycle after word 127; readback matches; CPU writes issued during the load have no effect.
REQ-042 BASE=0x40: address 0x3F -> miss; address 0x40 -> word 0; address 0xBF -> word 127; address 0xC0 -> miss.
REQ-043 reset_n low after 10 load words -> busy=0 immediately; words 0-9 hold new data, words 10-127 keep old data; a new load_start restarts at word 0.
